// File: rtl/card_pkg.sv
// card_pkg: card-deal constants, state encoding and popcount helper
package card_pkg;
    localparam int CARDS  = 4;
    localparam int CARD_W = 6;
    typedef logic [CARD_W-1:0]       card_t;
    typedef logic [CARDS*CARD_W-1:0] hand_t;
    localparam card_t LOW_CARD   = 6'b000011;
    localparam card_t EMPTY_CARD = 6'b000000;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] OVER  = 2'd3;
    localparam logic PLAYER   = 1'b0;
    localparam logic COMPUTER = 1'b1;
    function automatic logic [2:0] popcount(input logic [CARDS-1:0] m);
        popcount = 3'd0;
        for (int k = 0; k < CARDS; k++) popcount = popcount + {2'b0, m[k]};
    endfunction
endpackage

// File: rtl/hand_slot_bank.sv
// hand_slot_bank: one side's four card slots, live-card mask and remaining count
module hand_slot_bank
    import card_pkg::*;
(
    input  logic       clka,
    input  logic       restart_n,
    input  logic       clear,
    input  logic       load,
    input  logic       clear_slot,
    input  logic [1:0] slot_sel,
    input  hand_t      cards,
    output card_t      card,
    output logic       valid,
    output logic [2:0] count,
    output logic       has_low
);
    card_t            r_card [CARDS];
    logic [CARDS-1:0] r_mask;
    logic [2:0]       r_count;
    logic [CARDS-1:0] w_in_mask;
    logic [CARDS-1:0] w_low;

    for (genvar g = 0; g < CARDS; g++) begin : g_slot
        assign w_in_mask[g] = cards[g*CARD_W +: CARD_W] != EMPTY_CARD;
        assign w_low[g]     = r_card[g] == LOW_CARD;
    end

    assign card    = r_card[slot_sel];
    assign valid   = r_mask[slot_sel];
    assign count   = r_count;
    assign has_low = |w_low;

    // capture a dealt hand, or retire one played slot
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            for (int k = 0; k < CARDS; k++) r_card[k] <= EMPTY_CARD;
            r_mask  <= '0;
            r_count <= 3'd0;
        end else if (clear) begin
            for (int k = 0; k < CARDS; k++) r_card[k] <= EMPTY_CARD;
            r_mask  <= '0;
            r_count <= 3'd0;
        end else if (load) begin
            for (int k = 0; k < CARDS; k++) r_card[k] <= cards[k*CARD_W +: CARD_W];
            r_mask  <= w_in_mask;
            r_count <= popcount(w_in_mask);
        end else if (clear_slot && r_mask[slot_sel]) begin
            r_mask[slot_sel] <= 1'b0;
            r_count          <= (r_count != 3'd0) ? r_count - 3'd1 : r_count;
        end
    end
endmodule

// File: rtl/hand_reader.sv
// hand_reader: captures dealt hands and arbitrates turn-ordered card plays
module hand_reader
    import card_pkg::*;
(
    input  logic       clka,
    input  logic       restart_n,
    input  logic       deal_done,
    input  hand_t      player_cards,
    input  hand_t      comp_cards,
    input  logic       new_game,
    input  logic       play_req,
    input  logic       play_who,
    input  logic [1:0] play_slot,
    input  logic       play_pass,
    output logic       hands_valid,
    output logic       turn,
    output logic       play_ack,
    output card_t      play_card,
    output logic       play_err,
    output logic [2:0] player_left,
    output logic [2:0] comp_left,
    output logic       game_over,
    output logic       winner
);
    logic [1:0] r_state;
    logic       r_deal_q, r_turn, r_ack, r_err, r_winner;
    card_t      r_card;
    logic       w_rise, w_load, w_accept, w_play, w_last;
    card_t      w_p_card, w_c_card, w_card;
    logic       w_p_valid, w_c_valid, w_valid, w_p_low, w_c_low;
    logic [2:0] w_p_count, w_c_count, w_count;

    assign w_rise   = deal_done & ~r_deal_q;
    assign w_load   = (r_state == IDLE) & w_rise;
    assign w_card   = play_who ? w_c_card  : w_p_card;
    assign w_valid  = play_who ? w_c_valid : w_p_valid;
    assign w_count  = play_who ? w_c_count : w_p_count;
    assign w_accept = (r_state == READY) & play_req & (play_who == r_turn) & (play_pass | w_valid);
    assign w_play   = w_accept & ~play_pass;
    assign w_last   = w_play & (w_count == 3'd1);

    hand_slot_bank u_player (
        .clka(clka), .restart_n(restart_n), .clear(new_game), .load(w_load),
        .clear_slot(w_play & (play_who == PLAYER)), .slot_sel(play_slot), .cards(player_cards),
        .card(w_p_card), .valid(w_p_valid), .count(w_p_count), .has_low(w_p_low)
    );

    hand_slot_bank u_comp (
        .clka(clka), .restart_n(restart_n), .clear(new_game), .load(w_load),
        .clear_slot(w_play & (play_who == COMPUTER)), .slot_sel(play_slot), .cards(comp_cards),
        .card(w_c_card), .valid(w_c_valid), .count(w_c_count), .has_low(w_c_low)
    );

    // game sequencing, turn order and one-cycle ack/err responses
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_state  <= IDLE;
            r_deal_q <= 1'b0;
            r_turn   <= PLAYER;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_winner <= PLAYER;
            r_card   <= EMPTY_CARD;
        end else begin
            r_deal_q <= deal_done;
            r_ack    <= ~new_game & w_accept;
            r_err    <= ~new_game & play_req & ~w_accept;
            if (new_game) begin
                r_state  <= IDLE;
                r_turn   <= PLAYER;
                r_winner <= PLAYER;
            end else if (r_state == IDLE) begin
                if (w_rise) r_state <= LOAD;
            end else if (r_state == LOAD) begin
                r_turn   <= w_c_low & ~w_p_low;
                r_state  <= (w_p_count == 3'd0 || w_c_count == 3'd0) ? OVER : READY;
                r_winner <= (w_p_count != 3'd0) & (w_c_count == 3'd0);
            end else if (r_state == READY && w_accept) begin
                r_turn <= ~r_turn;
                if (w_play) r_card <= w_card;
                if (w_last) begin
                    r_state  <= OVER;
                    r_winner <= play_who;
                end
            end
        end
    end

    assign hands_valid = r_state == READY;
    assign game_over   = r_state == OVER;
    assign turn        = r_turn;
    assign play_ack    = r_ack;
    assign play_err    = r_err;
    assign play_card   = r_card;
    assign winner      = r_winner;
    assign player_left = w_p_count;
    assign comp_left   = w_c_count;
endmodule

// File: tb/tb_hand_reader.sv
// tb_hand_reader: table vectors, directed corner sequences and random play against a card-game model
module tb_hand_reader;
    logic        clka = 1'b0;
    logic        restart_n, deal_done, new_game, play_req, play_who, play_pass;
    logic [23:0] player_cards, comp_cards;
    logic [1:0]  play_slot;
    logic        hands_valid, turn, play_ack, play_err, game_over, winner;
    logic [5:0]  play_card;
    logic [2:0]  player_left, comp_left;
    int          n_cmp = 0;
    int          n_bad = 0;

    hand_reader dut (
        .clka(clka), .restart_n(restart_n), .deal_done(deal_done),
        .player_cards(player_cards), .comp_cards(comp_cards), .new_game(new_game),
        .play_req(play_req), .play_who(play_who), .play_slot(play_slot), .play_pass(play_pass),
        .hands_valid(hands_valid), .turn(turn), .play_ack(play_ack), .play_card(play_card),
        .play_err(play_err), .player_left(player_left), .comp_left(comp_left),
        .game_over(game_over), .winner(winner)
    );

    always #5 clka = ~clka;

    localparam logic [23:0] P1 = {6'h18, 6'h2A, 6'h06, 6'h03};
    localparam logic [23:0] C1 = {6'h1C, 6'h29, 6'h0C, 6'h35};
    localparam logic [23:0] P2 = {6'h0A, 6'h0B, 6'h0C, 6'h0D};
    localparam logic [23:0] C2 = {6'h00, 6'h00, 6'h11, 6'h03};

    // ---------------- reference model: hands as arrays, phase 0 idle / 1 dealt / 2 playing / 3 finished
    logic [5:0] m_hand [2][4];
    logic       m_live [2][4];
    int         m_ph;
    logic       m_turn, m_ack, m_err, m_win, m_dq;
    logic [5:0] m_card;

    function automatic int m_cnt(input int s);
        int n = 0;
        for (int k = 0; k < 4; k++) n += int'(m_live[s][k]);
        return n;
    endfunction

    function automatic logic m_has_low(input int s);
        for (int k = 0; k < 4; k++) if (m_live[s][k] && m_hand[s][k] == 6'h03) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear_hands();
        for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) begin
            m_hand[s][k] = 6'h00;
            m_live[s][k] = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_clear_hands();
        m_ph = 0; m_turn = 0; m_ack = 0; m_err = 0; m_win = 0; m_dq = 0; m_card = 6'h00;
    endtask

    task automatic m_step();
        logic rise;
        int   p, c, w;
        rise = deal_done && !m_dq;
        m_dq = deal_done;
        m_ack = 0;
        m_err = 0;
        if (new_game) begin
            m_ph = 0; m_turn = 0; m_win = 0;
            m_clear_hands();
            return;
        end
        if (m_ph != 2 && play_req) m_err = 1;
        if (m_ph == 0) begin
            if (rise) begin
                for (int k = 0; k < 4; k++) begin
                    m_hand[0][k] = player_cards[k*6 +: 6];
                    m_hand[1][k] = comp_cards[k*6 +: 6];
                    m_live[0][k] = m_hand[0][k] != 0;
                    m_live[1][k] = m_hand[1][k] != 0;
                end
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            p = m_cnt(0);
            c = m_cnt(1);
            m_turn = m_has_low(1) && !m_has_low(0);
            if (p == 0 || c == 0) begin
                m_ph = 3;
                m_win = (p != 0);
            end else m_ph = 2;
        end else if (m_ph == 2 && play_req) begin
            w = int'(play_who);
            if (play_who == m_turn && (play_pass || m_live[w][play_slot])) begin
                m_ack = 1;
                if (!play_pass) begin
                    m_card = m_hand[w][play_slot];
                    m_live[w][play_slot] = 0;
                    if (m_cnt(w) == 0) begin
                        m_ph = 3;
                        m_win = play_who;
                    end
                end
                m_turn = !m_turn;
            end else m_err = 1;
        end
    endtask

    // ---------------- checking
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("hands_valid", 32'(hands_valid), 32'(m_ph == 2));
        chk("game_over",   32'(game_over),   32'(m_ph == 3));
        chk("turn",        32'(turn),        32'(m_turn));
        chk("play_ack",    32'(play_ack),    32'(m_ack));
        chk("play_err",    32'(play_err),    32'(m_err));
        chk("play_card",   32'(play_card),   32'(m_card));
        chk("player_left", 32'(player_left), 32'(m_cnt(0)));
        chk("comp_left",   32'(comp_left),   32'(m_cnt(1)));
        chk("winner",      32'(winner),      32'(m_win));
    endtask

    task automatic cyc();
        @(posedge clka);
        #1;
        if (!restart_n) m_reset();
        else m_step();
        check_model();
    endtask

    task automatic req(input logic r, input logic w, input logic [1:0] s, input logic p);
        play_req = r; play_who = w; play_slot = s; play_pass = p;
    endtask

    // ---------------- table vectors
    typedef struct {
        logic       deal, ng, rq, who;
        logic [1:0] slot;
        logic       pass;
        logic       hv, trn, ack, err;
        logic [5:0] card;
        logic [2:0] pl, cl;
        logic       go, win;
    } vec_t;
    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1,1'b0,1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,1'b0,1'b0,6'h00,3'd4,3'd4,1'b0,1'b0};
        tbl[1] = '{1'b1,1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,1'b0,6'h00,3'd4,3'd4,1'b0,1'b0};
        tbl[2] = '{1'b1,1'b0,1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,1'b1,1'b0,6'h03,3'd3,3'd4,1'b0,1'b0};
        tbl[3] = '{1'b1,1'b0,1'b1,1'b0,2'd1,1'b0, 1'b1,1'b1,1'b0,1'b1,6'h03,3'd3,3'd4,1'b0,1'b0};
        tbl[4] = '{1'b1,1'b0,1'b1,1'b1,2'd2,1'b0, 1'b1,1'b0,1'b1,1'b0,6'h29,3'd3,3'd3,1'b0,1'b0};
        tbl[5] = '{1'b1,1'b0,1'b1,1'b0,2'd1,1'b0, 1'b1,1'b1,1'b1,1'b0,6'h06,3'd2,3'd3,1'b0,1'b0};
        tbl[6] = '{1'b1,1'b0,1'b1,1'b1,2'd2,1'b0, 1'b1,1'b1,1'b0,1'b1,6'h06,3'd2,3'd3,1'b0,1'b0};
        tbl[7] = '{1'b1,1'b0,1'b1,1'b1,2'd0,1'b1, 1'b1,1'b0,1'b1,1'b0,6'h06,3'd2,3'd3,1'b0,1'b0};
        tbl[8] = '{1'b1,1'b0,1'b0,1'b0,2'd0,1'b0, 1'b1,1'b0,1'b0,1'b0,6'h06,3'd2,3'd3,1'b0,1'b0};

        restart_n = 0; deal_done = 0; new_game = 0; player_cards = P1; comp_cards = C1;
        req(0, 0, 0, 0);
        #2;
        m_reset();
        check_model();
        cyc();
        restart_n = 1;
        cyc();

        for (int i = 0; i < 9; i++) begin
            deal_done = tbl[i].deal;
            new_game  = tbl[i].ng;
            req(tbl[i].rq, tbl[i].who, tbl[i].slot, tbl[i].pass);
            cyc();
            chk($sformatf("tbl%0d_hv", i),   32'(hands_valid), 32'(tbl[i].hv));
            chk($sformatf("tbl%0d_turn", i), 32'(turn),        32'(tbl[i].trn));
            chk($sformatf("tbl%0d_ack", i),  32'(play_ack),    32'(tbl[i].ack));
            chk($sformatf("tbl%0d_err", i),  32'(play_err),    32'(tbl[i].err));
            chk($sformatf("tbl%0d_card", i), 32'(play_card),   32'(tbl[i].card));
            chk($sformatf("tbl%0d_pl", i),   32'(player_left), 32'(tbl[i].pl));
            chk($sformatf("tbl%0d_cl", i),   32'(comp_left),   32'(tbl[i].cl));
            chk($sformatf("tbl%0d_go", i),   32'(game_over),   32'(tbl[i].go));
            chk($sformatf("tbl%0d_win", i),  32'(winner),      32'(tbl[i].win));
        end

        // computer holds the low card, two-card hand, computer wins
        req(0, 0, 0, 0);
        new_game = 1; deal_done = 0; cyc();
        new_game = 0; player_cards = P2; comp_cards = C2;
        deal_done = 1; cyc(); cyc();
        chk("a_turn", 32'(turn), 32'd1);
        chk("a_cl", 32'(comp_left), 32'd2);
        req(1, 1, 0, 0); cyc();
        chk("a_card1", 32'(play_card), 32'h03);
        req(1, 0, 0, 1); cyc();
        chk("a_pass_ack", 32'(play_ack), 32'd1);
        req(1, 1, 1, 0); cyc();
        chk("a_go", 32'(game_over), 32'd1);
        chk("a_win", 32'(winner), 32'd1);
        chk("a_ack2", 32'(play_ack), 32'd1);
        chk("a_card2", 32'(play_card), 32'h11);
        req(1, 1, 2, 0); cyc();
        chk("a_over_err1", 32'(play_err), 32'd1);
        req(1, 0, 0, 1); cyc();
        chk("a_over_err2", 32'(play_err), 32'd1);
        req(0, 0, 0, 0);

        // deal_done held high across new_game must not recapture
        new_game = 1; cyc();
        new_game = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("b_no_recapture_hv", 32'(hands_valid), 32'd0);
            chk("b_no_recapture_pl", 32'(player_left), 32'd0);
        end
        deal_done = 0; cyc();
        deal_done = 1; cyc(); cyc();
        chk("b_recapture_hv", 32'(hands_valid), 32'd1);

        // new_game beats a simultaneous request
        new_game = 1; req(1, 1, 0, 0); cyc();
        chk("c_ng_ack", 32'(play_ack), 32'd0);
        chk("c_ng_err", 32'(play_err), 32'd0);
        chk("c_ng_hv", 32'(hands_valid), 32'd0);
        new_game = 0; req(0, 0, 0, 0);

        // empty player hand ends the game during load with player as winner
        deal_done = 0; player_cards = 24'h0; comp_cards = C1; cyc();
        deal_done = 1; cyc(); cyc();
        chk("e_go", 32'(game_over), 32'd1);
        chk("e_win", 32'(winner), 32'd0);

        // asynchronous reset mid-game drops a request in flight
        new_game = 1; cyc();
        new_game = 0; deal_done = 0; player_cards = P1; cyc();
        deal_done = 1; cyc(); cyc();
        req(1, 0, 0, 0); cyc();
        chk("d_pre_card", 32'(play_card), 32'h03);
        req(1, 1, 0, 0);
        #2 restart_n = 0;
        #1;
        m_reset();
        check_model();
        chk("d_async_card", 32'(play_card), 32'h00);
        cyc();
        restart_n = 1; req(0, 0, 0, 0); deal_done = 0;
        cyc();
        chk("d_post_ack", 32'(play_ack), 32'd0);
        chk("d_post_err", 32'(play_err), 32'd0);

        // randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            logic [23:0] pc, cc;
            for (int k = 0; k < 4; k++) begin
                pc[k*6 +: 6] = ($urandom_range(0, 4) == 0) ? 6'h00 :
                               ($urandom_range(0, 5) == 0) ? 6'h03 : 6'($urandom_range(1, 63));
                cc[k*6 +: 6] = ($urandom_range(0, 4) == 0) ? 6'h00 :
                               ($urandom_range(0, 5) == 0) ? 6'h03 : 6'($urandom_range(1, 63));
            end
            player_cards = pc;
            comp_cards   = cc;
            new_game     = $urandom_range(0, 99) < 3;
            if ($urandom_range(0, 9) == 0) deal_done = ~deal_done;
            req($urandom_range(0, 9) < 6,
                ($urandom_range(0, 3) == 0) ? ~m_turn : m_turn,
                2'($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
